sync_f2s_rdq: RTL and testbench
===============================

SYNC_F2S_RDQ -- requirements
Module: sync_f2s_rdq

Interface
REQ-001 Parameter DW, default 16, read data width.
REQ-002 Parameter AW, default 8, read address width; address space 2**AW words.
REQ-003 Parameter RD_LAT, default 2, fixed memory read latency in clk_s cycles; legal range 1..4.
REQ-004 Parameter PEND_W, default 4, pending-request counter width.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk_s  input  1  slow-domain clock; all logic on its rising edge.
REQ-007 rst_s  input  1  synchronous active-high reset.
REQ-008 rd_en_i  input  1  synchronized read-request level from the fast-to-slow handshake synchronizer; may stay high for multiple cycles.
REQ-009 mem_rd_o  output  1  one-cycle memory read strobe.
REQ-010 mem_addr_o  output  AW  read address, valid while mem_rd_o=1.
REQ-011 mem_rdata_i  input  DW  memory data, valid exactly RD_LAT cycles after mem_rd_o.
REQ-012 dout_o  output  DW  output data.
REQ-013 dout_vld_o  output  1  output data valid.
REQ-014 dout_rdy_i  input  1  downstream ready; a transfer occurs when dout_vld_o and dout_rdy_i are both 1.
REQ-015 ovf_o  output  1  sticky flag: request lost because the pending counter was full.

Function
REQ-016 Each rising edge of rd_en_i (0 in cycle n-1, 1 in cycle n) SHALL count as exactly one request; a held-high level SHALL NOT add requests.
REQ-017 The pending counter SHALL increment on a request and decrement on a memory issue; both in the same cycle leaves it unchanged.
REQ-018 A request arriving while the counter is 2**PEND_W-1 with no same-cycle issue SHALL be dropped and SHALL set ovf_o.
REQ-019 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-020 IDLE -> ISSUE when pending>0 and the output register is empty, or is transferring in this cycle.
REQ-021 ISSUE: mem_rd_o=1 for exactly one cycle; the pending counter decrements; next state is WAIT.
REQ-022 WAIT SHALL count RD_LAT cycles, then capture mem_rdata_i into dout_o, set dout_vld_o, and go to HOLD.
REQ-023 HOLD: dout_o and dout_vld_o SHALL be stable until the transfer cycle.
REQ-024 On transfer in HOLD: go to ISSUE if pending>0, otherwise IDLE.
REQ-025 Request-to-dout_vld_o latency from an idle, empty block SHALL be RD_LAT+3 cycles (edge detect, IDLE, ISSUE, RD_LAT wait).
REQ-026 mem_addr_o SHALL start at 0, increment by 1 after each issue, and wrap from 2**AW-1 to 0.
REQ-027 Requests SHALL be counted during every state, including WAIT and HOLD.

Reset
REQ-028 Reset SHALL set the FSM to IDLE; mem_rd_o, dout_vld_o, ovf_o, the pending counter, mem_addr_o and the edge-detect register all to 0; dout_o to 0.
REQ-029 Reset asserted mid-read SHALL discard in-flight data; data returning after reset SHALL NOT be captured.
REQ-030 If rd_en_i is high on the first cycle after reset, no request SHALL be counted until it goes low and then high again.

Structure
REQ-031 A shared package sync_f2s_pkg SHALL hold the FSM state enumeration and the default parameter constants.
REQ-032 The edge detector and saturating counter SHALL be one sub-module, sync_f2s_req_cnt; the FSM, address counter and output register SHALL be in the top level.

Verification
REQ-033 Single pulse: rd_en_i high 3 cycles, RD_LAT=2, dout_rdy_i=1 -> one mem_rd_o at addr 0; dout_vld_o 5 cycles after the edge, with dout_o equal to the memory word at 0.
REQ-034 Backpressure: 3 edges, dout_rdy_i=0 for 20 cycles -> exactly one mem_rd_o; dout_o held; pending=2; after release, reads at addr 1 and 2 in order.
REQ-035 Overflow: PEND_W=4, 17 edges with dout_rdy_i=0 -> first read issued, pending saturates at 15, ovf_o=1 and stays 1 until reset.
REQ-036 Wrap: AW=2, 6 requests -> mem_addr_o sequence 0,1,2,3,0,1.
REQ-037 Reset in WAIT: rst_s asserted 1 cycle after mem_rd_o -> dout_vld_o stays 0, pending=0, next request reads addr 0.
REQ-038 Simultaneous: an edge in the same cycle as ISSUE with pending=1 -> pending stays 1 and the second read follows after the transfer.

Source files
------------

// File: rtl/sync_f2s_pkg.sv
// Shared definitions for the slow-domain read queue: FSM encoding and default sizing.
package sync_f2s_pkg;

    localparam int DW_DEF     = 16;
    localparam int AW_DEF     = 8;
    localparam int RD_LAT_DEF = 2;
    localparam int PEND_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_f2s_req_cnt.sv
// Rising-edge request detector feeding a saturating pending-request counter with a sticky overflow flag.
module sync_f2s_req_cnt
    import sync_f2s_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic              clk_s,
    input  logic              rst_s,
    input  logic              rd_en,
    input  logic              issue,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic rd_en_q;
    logic armed;
    logic req;

    // A level already high when reset releases must drop once before edges count.
    assign req = rd_en & ~rd_en_q & armed;

    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            rd_en_q <= 1'b0;
            armed   <= 1'b0;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            rd_en_q <= rd_en;
            armed   <= armed | ~rd_en;
            if (req && !issue) begin
                if (pending == PEND_MAX) begin
                    ovf <= 1'b1;
                end else begin
                    pending <= pending + 1'b1;
                end
            end else if (!req && issue) begin
                pending <= pending - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_f2s_rdq.sv
// Read queue: turns synchronized request edges into sequential memory reads and presents
// each returned word on a valid/ready output register.
module sync_f2s_rdq
    import sync_f2s_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic          clk_s,
    input  logic          rst_s,
    input  logic          rd_en_i,
    output logic          mem_rd_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [DW-1:0] dout_o,
    output logic          dout_vld_o,
    input  logic          dout_rdy_i,
    output logic          ovf_o
);

    state_t            state;
    state_t            state_nxt;
    logic [PEND_W-1:0] pending;
    logic [2:0]        wait_cnt;
    logic              issue;
    logic              xfer;
    logic              capture;

    assign issue    = (state == ISSUE);
    assign xfer     = dout_vld_o & dout_rdy_i;
    assign mem_rd_o = issue;
    assign capture  = (state == WAIT) && (wait_cnt == 3'(RD_LAT - 1));

    sync_f2s_req_cnt #(
        .PEND_W (PEND_W)
    ) u_req_cnt (
        .clk_s   (clk_s),
        .rst_s   (rst_s),
        .rd_en   (rd_en_i),
        .issue   (issue),
        .pending (pending),
        .ovf     (ovf_o)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((pending != '0) && (!dout_vld_o || xfer)) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (capture) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (xfer) begin
                    state_nxt = (pending != '0) ? ISSUE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset forces IDLE and clears the wait count, so a read still in flight is never captured.
    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            mem_addr_o <= '0;
            dout_o     <= '0;
            dout_vld_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (issue) begin
                mem_addr_o <= mem_addr_o + 1'b1;
            end
            if (capture) begin
                dout_o     <= mem_rdata_i;
                dout_vld_o <= 1'b1;
            end else if (xfer) begin
                dout_vld_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_f2s_rdq.sv
// Scoreboard bench for sync_f2s_rdq: directed scenarios followed by randomized traffic and resets.
module tb_sync_f2s_rdq;

    localparam int DW       = 16;
    localparam int AW       = 2;
    localparam int RD_LAT   = 2;
    localparam int PEND_W   = 4;
    localparam int PEND_MAX = (1 << PEND_W) - 1;

    logic          clk_s = 1'b0;
    logic          rst_s;
    logic          rd_en_i;
    logic          mem_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_rdata_i;
    logic [DW-1:0] dout_o;
    logic          dout_vld_o;
    logic          dout_rdy_i;
    logic          ovf_o;

    sync_f2s_rdq #(
        .DW     (DW),
        .AW     (AW),
        .RD_LAT (RD_LAT),
        .PEND_W (PEND_W)
    ) dut (
        .clk_s       (clk_s),
        .rst_s       (rst_s),
        .rd_en_i     (rd_en_i),
        .mem_rd_o    (mem_rd_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .dout_o      (dout_o),
        .dout_vld_o  (dout_vld_o),
        .dout_rdy_i  (dout_rdy_i),
        .ovf_o       (ovf_o)
    );

    always #5 clk_s = ~clk_s;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {4{2'b00, a}} ^ 16'hA5C3;
    endfunction

    // Memory: data for an issued read appears exactly RD_LAT cycles later; junk otherwise.
    logic          vp [RD_LAT];
    logic [AW-1:0] ap [RD_LAT];
    logic [DW-1:0] junk;

    always @(posedge clk_s) begin
        vp[0] <= mem_rd_o;
        ap[0] <= mem_addr_o;
        for (int i = 1; i < RD_LAT; i++) begin
            vp[i] <= vp[i-1];
            ap[i] <= ap[i-1];
        end
        junk <= DW'($urandom);
    end

    assign mem_rdata_i = vp[RD_LAT-1] ? mem_word(ap[RD_LAT-1]) : junk;

    int n_checks = 0;
    int n_fail   = 0;
    int issue_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got unexpected event, required none", name);
    endtask

    // Reference model: accepted requests queue addresses in order; data follows the same order.
    logic [AW-1:0] addr_q [$];
    logic [DW-1:0] data_q [$];
    logic          ovf_exp   = 1'b0;
    logic          prev_en   = 1'b0;
    logic          armed     = 1'b0;
    logic [AW-1:0] next_addr = '0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_dout = '0;

    always @(negedge clk_s) begin
        logic req;
        int   pend_pre;
        check("ovf", ovf_o, ovf_exp);
        req      = rd_en_i && !prev_en && armed;
        pend_pre = addr_q.size();
        if (mem_rd_o) begin
            issue_cnt++;
            if (addr_q.size() == 0) fail("spurious_read");
            else check("rd_addr", mem_addr_o, addr_q.pop_front());
        end
        if (req) begin
            if (pend_pre == PEND_MAX && !mem_rd_o) begin
                ovf_exp = 1'b1;
            end else begin
                addr_q.push_back(next_addr);
                data_q.push_back(mem_word(next_addr));
                next_addr = next_addr + 1'b1;
            end
        end
        if (hold_prev) begin
            check("hold_vld", dout_vld_o, 1'b1);
            check("hold_data", dout_o, prev_dout);
        end
        if (dout_vld_o && dout_rdy_i) begin
            if (data_q.size() == 0) fail("spurious_xfer");
            else check("dout", dout_o, data_q.pop_front());
        end
        hold_prev = dout_vld_o && !dout_rdy_i && !rst_s;
        prev_dout = dout_o;
        prev_en   = rd_en_i;
        armed     = armed | !rd_en_i;
        if (rst_s) begin
            addr_q.delete();
            data_q.delete();
            ovf_exp   = 1'b0;
            prev_en   = 1'b0;
            armed     = 1'b0;
            next_addr = '0;
            hold_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        rd_en_i = 1'b1;
        repeat (hi) tick();
        rd_en_i = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic do_reset();
        rst_s = 1'b1;
        tick();
        tick();
        rst_s = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_s);
            if (addr_q.size() == 0 && data_q.size() == 0 && !dout_vld_o) begin
                tick();
                return;
            end
        end
        fail("drain_timeout");
        tick();
    endtask

    initial begin
        int k;
        int base;
        rst_s      = 1'b1;
        rd_en_i    = 1'b1;
        dout_rdy_i = 1'b1;
        tick();
        tick();
        rst_s = 1'b0;

        // Reset state, with rd_en_i already high after reset (must not count).
        @(negedge clk_s);
        check("rst_mem_rd", mem_rd_o, 1'b0);
        check("rst_addr", mem_addr_o, '0);
        check("rst_vld", dout_vld_o, 1'b0);
        check("rst_dout", dout_o, '0);
        check("rst_ovf", ovf_o, 1'b0);
        base = issue_cnt;
        repeat (6) tick();
        @(negedge clk_s);
        check("held_after_rst_reads", issue_cnt - base, 0);
        rd_en_i = 1'b0;
        tick();
        tick();

        // Single request: latency from the edge to dout_vld_o.
        rd_en_i = 1'b1;
        k = 0;
        @(negedge clk_s);
        while (!dout_vld_o && k < 40) begin
            @(negedge clk_s);
            k++;
        end
        check("latency", k, RD_LAT + 3);
        tick();
        rd_en_i = 1'b0;
        wait_idle(100);

        // Backpressure: three requests, output stalled for 20 cycles.
        dout_rdy_i = 1'b0;
        base = issue_cnt;
        repeat (3) pulse(1, 1);
        repeat (20) tick();
        @(negedge clk_s);
        check("bp_reads", issue_cnt - base, 1);
        check("bp_vld", dout_vld_o, 1'b1);
        tick();
        dout_rdy_i = 1'b1;
        wait_idle(100);

        // Overflow: 17 requests with the output stalled.
        dout_rdy_i = 1'b0;
        repeat (17) pulse(1, 1);
        repeat (4) tick();
        @(negedge clk_s);
        check("ovf_set", ovf_o, 1'b1);
        tick();
        dout_rdy_i = 1'b1;
        wait_idle(300);
        @(negedge clk_s);
        check("ovf_sticky", ovf_o, 1'b1);
        tick();
        do_reset();
        @(negedge clk_s);
        check("ovf_cleared", ovf_o, 1'b0);
        check("addr_cleared", mem_addr_o, '0);
        tick();

        // Reset one cycle after a read is issued: the returning word is discarded.
        pulse(1, 0);
        k = 0;
        @(negedge clk_s);
        while (!mem_rd_o && k < 20) begin
            @(negedge clk_s);
            k++;
        end
        check("wait_rst_issue_seen", mem_rd_o, 1'b1);
        tick();
        do_reset();
        repeat (8) begin
            @(negedge clk_s);
            check("wait_rst_vld", dout_vld_o, 1'b0);
            tick();
        end
        pulse(1, 1);
        wait_idle(100);

        // Second edge in the same cycle as the first read issue.
        base = issue_cnt;
        pulse(1, 1);
        pulse(1, 1);
        wait_idle(100);
        check("simul_reads", issue_cnt - base, 2);

        // Randomized traffic with occasional resets and backpressure.
        repeat (1500) begin
            rd_en_i    = ($urandom_range(0, 99) < 35);
            dout_rdy_i = ($urandom_range(0, 99) < 60);
            rst_s      = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst_s      = 1'b0;
        rd_en_i    = 1'b0;
        dout_rdy_i = 1'b1;
        wait_idle(400);
        check("final_addr_q", addr_q.size(), 0);
        check("final_data_q", data_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
